// File: rtl/pin_sync_pkg.sv
// -----------------------------------------------------------------------------
// pin_sync_pkg
// Shared definitions for the pad input conditioning stage (pin_sync/pin_filt).
//   - default sizing constants
//   - filt_max(): stability count a pin must reach before a change is accepted
//   - pin_state_t: registered per-pin conditioned state (level + edge pulses)
//   - filt_act_e : per-cycle decision taken by the per-pin glitch filter
// Optional feature macro used by the importing modules: PIN_SYNC_EVENT_LATCH_EN
// -----------------------------------------------------------------------------
package pin_sync_pkg;

   localparam int NUMPINS_DEF     = 32;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int FILT_BITS_DEF   = 3;
   localparam int PRESCALE_W_DEF  = 8;

   // Saturation value of the stability counter: 2^bits - 1.
   function automatic int filt_max(input int bits);
      return (1 << bits) - 1;
   endfunction

   // Registered conditioned state of one pin.
   typedef struct packed {
      logic pin;    // conditioned level
      logic rise;   // 0->1 pulse, same edge as the level update
      logic fall;   // 1->0 pulse, same edge as the level update
   } pin_state_t;

   // What the filter does to one pin on the current edge.
   typedef enum logic [2:0] {
      ACT_FOLLOW,   // filter disabled: copy synced level, counter cleared
      ACT_CLEAR,    // synced agrees with pin_in: counter cleared
      ACT_HOLD,     // mismatch but no tick: counter holds
      ACT_COUNT,    // mismatch on a tick below saturation: counter increments
      ACT_ACCEPT    // mismatch on a tick at saturation: take new level
   } filt_act_e;

endpackage : pin_sync_pkg

// File: rtl/pin_filt.sv
// -----------------------------------------------------------------------------
// pin_filt
// One pad input: SYNC_STAGES-deep synchroniser, optional glitch filter with a
// stability counter advanced by the shared tick, registered level and one-cycle
// rise/fall pulses. Optional sticky event bits under PIN_SYNC_EVENT_LATCH_EN.
//
// Ports
//   clk_cog     in   clock
//   res         in   synchronous active-high reset
//   raw_i       in   asynchronous pad level
//   ena_i       in   filter enable (synchronous)
//   tick_i      in   filter tick from the shared prescaler
//   pin_o       out  conditioned level (registered)
//   rise_o      out  one-cycle pulse on 0->1 of pin_o
//   fall_o      out  one-cycle pulse on 1->0 of pin_o
//   evt_clr_i   in   clear for sticky event bits      (PIN_SYNC_EVENT_LATCH_EN)
//   evt_rise_o  out  sticky rise event                (PIN_SYNC_EVENT_LATCH_EN)
//   evt_fall_o  out  sticky fall event                (PIN_SYNC_EVENT_LATCH_EN)
// -----------------------------------------------------------------------------
module pin_filt
   import pin_sync_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_BITS   = FILT_BITS_DEF
) (
   input  logic clk_cog,
   input  logic res,
   input  logic raw_i,
   input  logic ena_i,
   input  logic tick_i,
   output logic pin_o,
   output logic rise_o,
   output logic fall_o
`ifdef PIN_SYNC_EVENT_LATCH_EN
   ,
   input  logic evt_clr_i,
   output logic evt_rise_o,
   output logic evt_fall_o
`endif
);

   localparam logic [FILT_BITS-1:0] CNT_MAX = FILT_BITS'(filt_max(FILT_BITS));

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FILT_BITS-1:0]   cnt_q, cnt_d;
   pin_state_t             st_q, st_d;
   filt_act_e              act;
   logic                   synced;
   logic                   pin_nxt;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case below can leave a value unassigned and infer a latch.
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};  // pure shift, no logic between stages
      synced  = sync_q[SYNC_STAGES-1];
      cnt_d   = cnt_q;
      pin_nxt = st_q.pin;

      if (!ena_i)                 act = ACT_FOLLOW;
      else if (synced == st_q.pin) act = ACT_CLEAR;
      else if (!tick_i)           act = ACT_HOLD;
      else if (cnt_q == CNT_MAX)  act = ACT_ACCEPT;
      else                        act = ACT_COUNT;

      case (act)
         ACT_FOLLOW: begin
            pin_nxt = synced;
            cnt_d   = '0;
         end
         ACT_CLEAR:  cnt_d = '0;
         ACT_HOLD:   cnt_d = cnt_q;
         ACT_COUNT:  cnt_d = cnt_q + 1'b1;
         ACT_ACCEPT: begin
            pin_nxt = synced;
            cnt_d   = '0;
         end
         default:    cnt_d = '0;
      endcase

      st_d.pin  = pin_nxt;
      st_d.rise = pin_nxt & ~st_q.pin;
      st_d.fall = ~pin_nxt & st_q.pin;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample
   // the pre-edge values, which keeps the synchroniser a true shift chain.
   always_ff @(posedge clk_cog) begin
      // NOTE: synchroniser flops are reset too, so after release a pin held
      // high is seen as a genuine 0->1 transition and produces a rise pulse.
      if (res) begin
         sync_q <= '0;
         cnt_q  <= '0;
         st_q   <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         st_q   <= st_d;
      end
   end

   assign pin_o  = st_q.pin;
   assign rise_o = st_q.rise;
   assign fall_o = st_q.fall;

`ifdef PIN_SYNC_EVENT_LATCH_EN
   logic evt_rise_q, evt_rise_d;
   logic evt_fall_q, evt_fall_d;

   // Set comes from the registered pulse and wins over a coincident clear.
   always_comb begin
      evt_rise_d = st_q.rise | (evt_rise_q & ~evt_clr_i);
      evt_fall_d = st_q.fall | (evt_fall_q & ~evt_clr_i);
   end

   always_ff @(posedge clk_cog) begin
      if (res) begin
         evt_rise_q <= 1'b0;
         evt_fall_q <= 1'b0;
      end else begin
         evt_rise_q <= evt_rise_d;
         evt_fall_q <= evt_fall_d;
      end
   end

   assign evt_rise_o = evt_rise_q;
   assign evt_fall_o = evt_fall_q;
`endif

endmodule : pin_filt

// File: rtl/pin_sync.sv
// -----------------------------------------------------------------------------
// pin_sync
// Input conditioning stage feeding the core's pin_in bus. Synchronises NUMPINS
// asynchronous pads into clk_cog, optionally glitch-filters each pin, and emits
// one-cycle rise/fall pulses. A single prescaler provides the filter tick
// shared by all pins. All outputs are registered.
//
// Ports
//   clk_cog   in   cog clock (only clock)
//   res       in   synchronous active-high reset
//   pin_raw   in   [NUMPINS]    asynchronous pad inputs
//   filt_ena  in   [NUMPINS]    per-pin filter enable
//   prescale  in   [PRESCALE_W] tick every prescale+1 cycles
//   pin_in    out  [NUMPINS]    conditioned pin state
//   pin_rise  out  [NUMPINS]    one-cycle 0->1 pulses
//   pin_fall  out  [NUMPINS]    one-cycle 1->0 pulses
//   evt_clr   in   [NUMPINS]    sticky event clear  (PIN_SYNC_EVENT_LATCH_EN)
//   evt_rise  out  [NUMPINS]    sticky rise events  (PIN_SYNC_EVENT_LATCH_EN)
//   evt_fall  out  [NUMPINS]    sticky fall events  (PIN_SYNC_EVENT_LATCH_EN)
//
// Optional feature macro: PIN_SYNC_EVENT_LATCH_EN
// -----------------------------------------------------------------------------
module pin_sync
   import pin_sync_pkg::*;
#(
   parameter int NUMPINS     = NUMPINS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,   // legal 2..4
   parameter int FILT_BITS   = FILT_BITS_DEF,
   parameter int PRESCALE_W  = PRESCALE_W_DEF
) (
   input  logic                  clk_cog,
   input  logic                  res,
   input  logic [NUMPINS-1:0]    pin_raw,
   input  logic [NUMPINS-1:0]    filt_ena,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [NUMPINS-1:0]    pin_in,
   output logic [NUMPINS-1:0]    pin_rise,
   output logic [NUMPINS-1:0]    pin_fall
`ifdef PIN_SYNC_EVENT_LATCH_EN
   ,
   input  logic [NUMPINS-1:0]    evt_clr,
   output logic [NUMPINS-1:0]    evt_rise,
   output logic [NUMPINS-1:0]    evt_fall
`endif
);

   // Prescaler: down-counter that ticks and reloads when it reaches zero.
   // Reset leaves it at zero, so the first cycle out of reset ticks. A new
   // prescale value is only picked up at a reload.
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  tick;

   always_comb begin
      tick    = (presc_q == '0);
      presc_d = tick ? prescale : presc_q - 1'b1;
   end

   always_ff @(posedge clk_cog) begin
      if (res) presc_q <= '0;
      else     presc_q <= presc_d;
   end

   for (genvar g = 0; g < NUMPINS; g++) begin : g_pin
      pin_filt #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_BITS   (FILT_BITS)
      ) u_pin_filt (
         .clk_cog    (clk_cog),
         .res        (res),
         .raw_i      (pin_raw[g]),
         .ena_i      (filt_ena[g]),
         .tick_i     (tick),
         .pin_o      (pin_in[g]),
         .rise_o     (pin_rise[g]),
         .fall_o     (pin_fall[g])
`ifdef PIN_SYNC_EVENT_LATCH_EN
         ,
         .evt_clr_i  (evt_clr[g]),
         .evt_rise_o (evt_rise[g]),
         .evt_fall_o (evt_fall[g])
`endif
      );
   end

endmodule : pin_sync
